merge_arbiter: RTL and testbench
================================

Name: merge_arbiter

Overview:
- Shares one pipelined merge datapath between two requesters. The datapath is a registered operand stage plus a select-or-add unit (pass operand A, or output A+B).
- Performs round-robin arbitration, moves operands through two pipeline register stages, and registers the merged result with the winning requester's ID.
- Sits in front of the merge unit and is the only block allowed to drive it.

Parameters:
- W, 8, operand and result width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle when valid and ready are both high.
- req0_a  input  W  requester 0 operand A.
- req0_b  input  W  requester 0 operand B.
- req0_add  input  1  requester 0 mode: 1 = A+B, 0 = pass A.
- req1_valid, req1_ready, req1_a, req1_b, req1_add: same as requester 0, for requester 1.
- out_valid  output  1  result present on out_data/out_id.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  merged result.
- out_id  output  1  ID of the requester that produced out_data.
- busy  output  1  any pipeline stage (s1, s2, out) holds a valid entry.

Behaviour:
- Reset (rst=1 at an edge):
  - s1/s2/out valid bits cleared; all data and ID registers set to 0; round-robin pointer rr set to 0.
  - Outputs after reset: out_valid=0, out_data=0, out_id=0, busy=0.
  - req*_ready = 0 in any cycle where rst=1.
  - Reset mid-operation discards every in-flight entry; nothing is ever emitted for it.
- Advance condition: adv = !out_valid || out_ready. When adv=0, every stage and rr hold their values.
- Ready logic (independent of own valid):
  - req0_ready = adv && !rst && (rr==0 || !req1_valid).
  - req1_ready = adv && !rst && (rr==1 || !req0_valid).
- Grant:
  - grant_i = req_i_valid && req_i_ready; at most one grant per cycle.
  - On any grant to i, rr <= the other requester. With no grant, rr holds.
- Pipeline (all updates only when adv=1):
  - Stage s1: captures a, b, add and id of the granted requester; s1_valid <= any grant. With no grant, a bubble is inserted (s1_valid=0) and the data fields are don't-care.
  - Stage s2: s2 <= s1, including the valid bit.
  - Out stage: out_valid <= s2_valid; out_id <= s2_id; out_data <= (s2_add ? s2_a + s2_b : s2_a).
- Arithmetic: the sum is truncated to W bits (mod 2^W); no carry out.
- Latency and throughput:
  - An operation accepted in cycle t appears on the outputs in cycle t+3 when there is no stall.
  - Throughput is 1 operation per cycle.
  - Results emerge in acceptance order.
- Backpressure:
  - While out_valid=1 and out_ready=0: out_* held stable, s1/s2 frozen, both ready=0.
  - No entry is lost or duplicated.
  - Bubbles are not compressed under stall; the whole pipeline holds.
- Fairness: with both requesters continuously valid and adv=1, grants strictly alternate, starting with whichever requester rr indicates.
- Output handshake: an entry is consumed when out_valid && out_ready. With the pipeline empty, out_valid falls in the cycle after the last consume.
- busy = s1_valid || s2_valid || out_valid.

Test Plan:
1. After reset, req0 alone with a=3, b=5, add=1, valid for one cycle t, out_ready=1 -> cycle t+3 shows out_valid=1, out_data=8, out_id=0; out_valid=0 at t+4; busy=0 at t+4.
2. req1 alone with a=0xAA, b=0x11, add=0 -> out_data=0xAA, out_id=1, 3 cycles later; rr=0 afterwards.
3. Wrap check, W=8: req0 with a=0xF0, b=0x20, add=1 -> out_data=0x10.
4. Both requesters valid for 4 consecutive cycles from reset, distinct operands, out_ready=1:
   - grants go 0,1,0,1;
   - results appear on consecutive cycles with out_id 0,1,0,1 and correct sums.
5. Pipeline full, out_ready held 0 for 2 cycles:
   - out_data/out_id stable, req*_ready=0, no new acceptances;
   - after out_ready=1, the remaining results drain in order with no loss or duplication.
6. Two operations accepted, then rst=1 for one cycle before either emerges:
   - out_valid stays 0 afterwards with no stale results and busy=0;
   - next simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/merge_arbiter.sv
// Two-requester round-robin front end for a pipelined select-or-add merge unit.
// Operation path: grant -> s1 operand register -> s2 -> registered result with the requester ID.
module merge_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_add,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_add,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_id,

    output logic         busy
);

    logic         adv;
    logic         rr;
    logic         grant0;
    logic         grant1;

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic         s1_add;
    logic         s1_id;

    logic         s2_valid;
    logic [W-1:0] s2_a;
    logic [W-1:0] s2_b;
    logic         s2_add;
    logic         s2_id;

    logic [W-1:0] s2_sum;

    // The whole pipeline moves as one unit: any stall at the output freezes every stage.
    assign adv = !out_valid || out_ready;

    // When both requesters are valid, only the one that rr points at sees ready,
    // so the two grants are mutually exclusive by construction.
    assign req0_ready = adv && !rst && (!rr || !req1_valid);
    assign req1_ready = adv && !rst && (rr || !req0_valid);

    assign grant0 = req0_valid && req0_ready;
    assign grant1 = req1_valid && req1_ready;

    assign s2_sum = s2_a + s2_b;
    assign busy   = s1_valid || s2_valid || out_valid;

    // NOTE: all state uses non-blocking assignments so every stage samples the pre-edge values of its source.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= 1'b0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_add    <= 1'b0;
            s1_id     <= 1'b0;
            s2_valid  <= 1'b0;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_add    <= 1'b0;
            s2_id     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
        end else if (adv) begin
            if (grant0) begin
                rr <= 1'b1;
            end else if (grant1) begin
                rr <= 1'b0;
            end

            // Data fields of a bubble are don't-care, so the mux only looks at grant1.
            s1_valid <= grant0 || grant1;
            s1_a     <= grant1 ? req1_a   : req0_a;
            s1_b     <= grant1 ? req1_b   : req0_b;
            s1_add   <= grant1 ? req1_add : req0_add;
            s1_id    <= grant1;

            s2_valid <= s1_valid;
            s2_a     <= s1_a;
            s2_b     <= s1_b;
            s2_add   <= s1_add;
            s2_id    <= s1_id;

            out_valid <= s2_valid;
            out_data  <= s2_add ? s2_sum : s2_a;
            out_id    <= s2_id;
        end
    end

endmodule

// File: tb/tb_merge_arbiter.sv
// Self-checking bench for merge_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a conveyor-belt model and an in-order scoreboard.
module tb_merge_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_add;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_add;
    logic [W-1:0] req1_a, req1_b;
    logic         out_valid, out_ready, out_id, busy;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    merge_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_add   (req0_add),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_add   (req1_add),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .busy       (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         id;
    } res_t;

    // Model: three slots carrying finished results (slot 2 is the output), a turn
    // pointer, and a queue of everything accepted and not yet consumed.
    logic         m_v  [3];
    logic [W-1:0] m_d  [3];
    logic         m_id [3];
    logic         m_turn;
    res_t         acc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] a, input logic [W-1:0] b, input logic add);
        logic [W-1:0] sum;
        sum = a + b;
        return add ? sum : a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i]  = 1'b0;
            m_d[i]  = '0;
            m_id[i] = 1'b0;
        end
        m_turn = 1'b0;
        acc_q.delete();
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_add = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_add = 1'b0;
    endtask

    // Called just after a negedge with inputs applied: compare, advance the model, move to the next negedge.
    task automatic tick();
        logic e_adv, e0, e1;
        res_t r;
        #1;
        e_adv = !m_v[2] || out_ready;
        e0 = !rst && e_adv && (m_turn == 1'b0 || !req1_valid);
        e1 = !rst && e_adv && (m_turn == 1'b1 || !req0_valid);
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("out_valid", out_valid, m_v[2]);
        check("busy", busy, m_v[0] || m_v[1] || m_v[2]);
        if (m_v[2]) begin
            check("out_data", out_data, m_d[2]);
            check("out_id", out_id, m_id[2]);
        end
        if (!rst && m_v[2] && out_ready) begin
            if (acc_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard: got result 0x%0h, expected nothing outstanding", out_data);
            end else begin
                r = acc_q.pop_front();
                check("sb_data", out_data, r.data);
                check("sb_id", out_id, r.id);
            end
        end
        if (rst) begin
            model_reset();
        end else if (e_adv) begin
            for (int i = 2; i > 0; i--) begin
                m_v[i]  = m_v[i-1];
                m_d[i]  = m_d[i-1];
                m_id[i] = m_id[i-1];
            end
            m_v[0] = 1'b0;
            if (req0_valid && e0) begin
                m_v[0] = 1'b1; m_d[0] = merge(req0_a, req0_b, req0_add); m_id[0] = 1'b0;
                m_turn = 1'b1;
            end else if (req1_valid && e1) begin
                m_v[0] = 1'b1; m_d[0] = merge(req1_a, req1_b, req1_add); m_id[0] = 1'b1;
                m_turn = 1'b0;
            end
            if (m_v[0]) begin
                r.data = m_d[0];
                r.id   = m_id[0];
                acc_q.push_back(r);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic         ov  [7];
    logic [W-1:0] od  [7];
    logic         oid [7];
    logic [W-1:0] t4_data [4];
    logic         t4_id   [4];

    initial begin
        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_busy", busy, 0);

        // 1: single add from requester 0, three-cycle latency
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd5; req0_add = 1'b1;
        #1;
        check("t1_ready", req0_ready, 1);
        tick();
        idle();
        tick();
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 8'd8);
        check("t1_id", out_id, 0);
        tick();
        check("t1_valid_after", out_valid, 0);
        check("t1_busy_after", busy, 0);

        // 2: pass-through from requester 1, then the pointer returns to requester 0
        req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h11; req1_add = 1'b0;
        tick();
        idle();
        tick();
        tick();
        check("t2_data", out_data, 8'hAA);
        check("t2_id", out_id, 1);
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("t2_rr_req0", req0_ready, 1);
        check("t2_rr_req1", req1_ready, 0);
        idle();

        // 3: sum wraps modulo 2^W
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h20; req0_add = 1'b1;
        tick();
        idle();
        tick();
        tick();
        check("t3_wrap", out_data, 8'h10);
        tick();

        // 4: both requesters valid for four cycles -> alternating grants and results
        do_reset();
        t4_data[0] = 8'd11;  t4_id[0] = 1'b0;
        t4_data[1] = 8'h41;  t4_id[1] = 1'b1;
        t4_data[2] = 8'd13;  t4_id[2] = 1'b0;
        t4_data[3] = 8'h43;  t4_id[3] = 1'b1;
        for (int j = 0; j < 7; j++) begin
            if (j < 4) begin
                req0_valid = 1'b1; req0_a = W'(j + 1);    req0_b = 8'd10; req0_add = 1'b1;
                req1_valid = 1'b1; req1_a = W'(8'h40 + j); req1_b = 8'd1;  req1_add = 1'b0;
                #1;
                check("t4_grant0", req0_ready, (j % 2 == 0) ? 1 : 0);
                check("t4_grant1", req1_ready, (j % 2 == 0) ? 0 : 1);
            end else begin
                idle();
            end
            tick();
            ov[j] = out_valid; od[j] = out_data; oid[j] = out_id;
        end
        for (int j = 0; j < 4; j++) begin
            check("t4_valid", ov[j+2], 1);
            check("t4_data", od[j+2], t4_data[j]);
            check("t4_id", oid[j+2], t4_id[j]);
        end
        check("t4_valid_end", ov[6], 0);

        // 5: full pipeline, output stalled for two cycles, then drain in order
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_a = W'(8'h21 + k); req0_b = 8'h00; req0_add = 1'b0;
            tick();
        end
        req0_a = 8'h24;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t5_stall_data", out_data, 8'h21);
            check("t5_stall_id", out_id, 0);
            check("t5_stall_ready0", req0_ready, 0);
            check("t5_stall_ready1", req1_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check("t5_drain0", out_data, 8'h21);
        tick();
        idle();
        check("t5_drain1", out_data, 8'h22);
        tick();
        check("t5_drain2", out_data, 8'h23);
        tick();
        check("t5_drain3", out_data, 8'h24);
        check("t5_drain3_valid", out_valid, 1);
        tick();
        check("t5_empty", out_valid, 0);

        // 6: reset discards in-flight work and restores the pointer
        do_reset();
        req1_valid = 1'b1; req1_a = 8'h31; req1_add = 1'b0;
        tick();
        idle();
        req0_valid = 1'b1; req0_a = 8'h32; req0_add = 1'b0;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t6_no_stale", out_valid, 0);
            check("t6_busy", busy, 0);
            tick();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("t6_grant0", req0_ready, 1);
        check("t6_grant1", req1_ready, 0);
        tick();
        idle();

        // Randomized traffic with stalls and occasional resets
        for (int c = 0; c < 3000; c++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req0_a     = W'($urandom);
            req0_b     = W'($urandom);
            req0_add   = W'($urandom_range(0, 1)) != 0;
            req1_valid = ($urandom_range(0, 99) < 60);
            req1_a     = W'($urandom);
            req1_b     = W'($urandom);
            req1_add   = W'($urandom_range(0, 1)) != 0;
            out_ready  = ($urandom_range(0, 99) < 70);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("drain_empty", acc_q.size(), 0);
        check("drain_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
